// File: rtl/updn_counter_chain.sv
// Cascaded up/down counter: STAGES x STAGE_W-bit digits, wrap/saturate, sticky flags.
// Optional decimal digits when UPDN_CHAIN_BCD_EN is defined.
module updn_counter_chain #(
    parameter int STAGE_W = 4,
    parameter int STAGES  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        load,
    input  logic [STAGES*STAGE_W-1:0]   din,
    input  logic                        eup,
    input  logic                        edn,
    input  logic                        sat,
    output logic [STAGES*STAGE_W-1:0]   qout,
    output logic                        cout,
    output logic                        bout,
    output logic                        ovf,
    output logic                        unf
);

    localparam int W = STAGES * STAGE_W;
`ifdef UPDN_CHAIN_BCD_EN
    localparam logic [STAGE_W-1:0] L_MAX = STAGE_W'(9);
`else
    localparam logic [STAGE_W-1:0] L_MAX = '1;
`endif
    localparam logic [STAGE_W-1:0] L_ONE = STAGE_W'(1);

    logic [W-1:0]  r_q;
    logic          r_ovf;
    logic          r_unf;

    logic          w_up;
    logic          w_dn;
    logic [STAGES:0] w_pmax;
    logic [STAGES:0] w_pmin;
    logic [W-1:0]  w_next;
    logic [W-1:0]  w_ld;

    // Conflicting or absent enables mean hold.
    assign w_up = eup & ~edn;
    assign w_dn = edn & ~eup;

    // Ripple enables, per-digit next values and load-value conditioning.
    always_comb begin
        logic [STAGE_W-1:0] v_dig;
`ifdef UPDN_CHAIN_BCD_EN
        logic [STAGE_W-1:0] v_din;
        v_din = '0;
`endif
        v_dig     = '0;
        w_pmax    = '0;
        w_pmin    = '0;
        w_next    = r_q;
        w_ld      = din;
        w_pmax[0] = 1'b1;
        w_pmin[0] = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            v_dig = r_q[k*STAGE_W +: STAGE_W];
            w_pmax[k+1] = w_pmax[k] & (v_dig == L_MAX);
            w_pmin[k+1] = w_pmin[k] & (v_dig == '0);
            if (w_up && w_pmax[k]) begin
                w_next[k*STAGE_W +: STAGE_W] =
                    (v_dig == L_MAX) ? '0 : v_dig + L_ONE;
            end else if (w_dn && w_pmin[k]) begin
                w_next[k*STAGE_W +: STAGE_W] =
                    (v_dig == '0) ? L_MAX : v_dig - L_ONE;
            end
`ifdef UPDN_CHAIN_BCD_EN
            v_din = din[k*STAGE_W +: STAGE_W];
            if (v_din > L_MAX) begin
                w_ld[k*STAGE_W +: STAGE_W] = L_MAX;
            end
`endif
        end
    end

    assign cout = w_up & w_pmax[STAGES];
    assign bout = w_dn & w_pmin[STAGES];

    // Count register and sticky flags: clr > load > count > hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (clr) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (load) begin
            r_q <= w_ld;
        end else if (cout) begin
            r_ovf <= 1'b1;
            if (!sat) begin
                r_q <= w_next;
            end
        end else if (bout) begin
            r_unf <= 1'b1;
            if (!sat) begin
                r_q <= w_next;
            end
        end else begin
            r_q <= w_next;
        end
    end

    assign qout = r_q;
    assign ovf  = r_ovf;
    assign unf  = r_unf;

endmodule

// File: tb/tb_updn_counter_chain.sv
// Scoreboard bench for updn_counter_chain (STAGE_W=4, STAGES=2).
// Each row: inputs for this cycle plus expected state/carry sampled before its edge.
module tb_updn_counter_chain;

    typedef struct {
        int         row;
        logic [7:0] q;
        logic       ovf;
        logic       unf;
        logic       c;
        logic       b;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       load;
    logic [7:0] din;
    logic       eup;
    logic       edn;
    logic       sat;
    logic [7:0] qout;
    logic       cout;
    logic       bout;
    logic       ovf;
    logic       unf;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   row   = 0;

    updn_counter_chain #(.STAGE_W(4), .STAGES(2)) dut (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .load (load),
        .din  (din),
        .eup  (eup),
        .edn  (edn),
        .sat  (sat),
        .qout (qout),
        .cout (cout),
        .bout (bout),
        .ovf  (ovf),
        .unf  (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int r, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, r, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its expectation.
    task automatic vec(input bit rst, input bit c, input bit l, input logic [7:0] d,
                       input bit u, input bit dn, input bit s,
                       input logic [7:0] eq, input bit eo, input bit eu,
                       input bit ec, input bit eb);
        exp_t e;
        @(negedge clk);
        reset = 1'b0;
        clr   = c;
        load  = l;
        din   = d;
        eup   = u;
        edn   = dn;
        sat   = s;
        e.row = row;
        e.q   = eq;
        e.ovf = eo;
        e.unf = eu;
        e.c   = ec;
        e.b   = eb;
        sb.push_back(e);
        row++;
        if (rst) begin
            #2 reset = 1'b1;
        end
    endtask

    // Monitor: sample just before the rising edge and check queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("qout", e.row, int'(qout), int'(e.q));
                chk("ovf",  e.row, int'(ovf),  int'(e.ovf));
                chk("unf",  e.row, int'(unf),  int'(e.unf));
                chk("cout", e.row, int'(cout), int'(e.c));
                chk("bout", e.row, int'(bout), int'(e.b));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        clr   = 1'b0;
        load  = 1'b0;
        din   = 8'h00;
        eup   = 1'b0;
        edn   = 1'b0;
        sat   = 1'b0;
`ifdef UPDN_CHAIN_BCD_EN
        //  rst clr ld din   up dn sat  q     ovf unf c b
        vec(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        vec(0, 0, 1, 8'h99, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 1, 0, 0, 8'h99, 0, 0, 1, 0);
        vec(0, 0, 1, 8'h10, 0, 0, 0, 8'h00, 1, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 0, 1, 0, 8'h10, 1, 0, 0, 0);
        vec(0, 0, 1, 8'hAF, 0, 0, 0, 8'h09, 1, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 1, 0, 1, 8'h99, 1, 0, 1, 0);
        vec(0, 0, 0, 8'h00, 0, 1, 0, 8'h99, 1, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 0, 0, 0, 8'h98, 1, 0, 0, 0);
`else
        //  rst clr ld din   up dn sat  q     ovf unf c b
        // reset and count 3
        vec(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 1, 0, 0, 8'h01, 0, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 1, 0, 0, 8'h02, 0, 0, 0, 0);
        vec(0, 0, 1, 8'h5A, 0, 0, 0, 8'h03, 0, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 1, 0, 0, 8'h5A, 0, 0, 0, 0);
        // async reset mid-count: qout 0 before the next edge
        vec(1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        // ripple carry / borrow across the digit boundary
        vec(0, 0, 1, 8'h0F, 0, 0, 0, 8'h01, 0, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 1, 0, 0, 8'h0F, 0, 0, 0, 0);
        vec(0, 0, 1, 8'h10, 0, 0, 0, 8'h10, 0, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 0, 1, 0, 8'h10, 0, 0, 0, 0);
        // wrap mode
        vec(0, 0, 1, 8'hFF, 0, 0, 0, 8'h0F, 0, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 1, 0, 0, 8'hFF, 0, 0, 1, 0);
        vec(0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 0, 1);
        // saturate mode
        vec(0, 0, 1, 8'hFE, 0, 0, 1, 8'hFF, 1, 1, 0, 0);
        vec(0, 0, 0, 8'h00, 1, 0, 1, 8'hFE, 1, 1, 0, 0);
        vec(0, 0, 0, 8'h00, 1, 0, 1, 8'hFF, 1, 1, 1, 0);
        vec(0, 0, 0, 8'h00, 1, 0, 1, 8'hFF, 1, 1, 1, 0);
        vec(0, 0, 0, 8'h00, 0, 0, 1, 8'hFF, 1, 1, 0, 0);
        vec(1'b0, 1, 0, 8'h00, 0, 0, 1, 8'hFF, 1, 1, 0, 0);
        vec(0, 0, 0, 8'h00, 0, 1, 1, 8'h00, 0, 0, 0, 1);
        vec(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 0);
        // priority and direction conflict
        vec(0, 0, 1, 8'h33, 0, 0, 0, 8'h00, 0, 1, 0, 0);
        vec(0, 0, 0, 8'h00, 1, 1, 0, 8'h33, 0, 1, 0, 0);
        vec(0, 1, 1, 8'h77, 1, 0, 0, 8'h33, 0, 1, 0, 0);
        vec(0, 0, 1, 8'h42, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        vec(0, 0, 1, 8'hFF, 0, 0, 0, 8'h42, 0, 0, 0, 0);
        vec(0, 0, 0, 8'h00, 1, 1, 0, 8'hFF, 0, 0, 0, 0);
        // sat applies only to the edge it is presented on
        vec(0, 0, 0, 8'h00, 1, 0, 0, 8'hFF, 0, 0, 1, 0);
        vec(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 1, 0, 0, 0);
`endif
        // let the monitor drain the last expectation, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            #6;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/updn_counter_chain.md
Name: updn_counter_chain

Overview:
- Parametrised cascade of STAGES identical up/down counter stages, each STAGE_W bits wide, forming one STAGES*STAGE_W-bit counter.
- Next generation of the team's two-stage up/down cascade. Adds:
  - arbitrary stage count and width;
  - synchronous clear and parallel load;
  - selectable wrap or saturate mode;
  - a sticky overflow/underflow flag.
- Used as an event/position counter in the counter library; stage boundaries are exposed for digit-wise display.

Parameters:
- STAGE_W, 4, bit width of one stage (min 1; min 4 when BCD enabled)
- STAGES, 2, number of cascaded stages (min 1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- clr  input  1  synchronous clear of count and sticky flags
- load  input  1  synchronous parallel load from din
- din  input  STAGES*STAGE_W  load value, stage 0 in LSBs
- eup  input  1  count-up enable
- edn  input  1  count-down enable
- sat  input  1  mode: 1 = saturate at limits, 0 = wrap
- qout  output  STAGES*STAGE_W  registered count, stage k at bits [k*STAGE_W +: STAGE_W]
- cout  output  1  combinational carry out of the top stage
- bout  output  1  combinational borrow out of the top stage
- ovf  output  1  registered sticky overflow flag
- unf  output  1  registered sticky underflow flag

Behaviour:
- Reset (async, active-high): qout=0, ovf=0, unf=0, taking effect immediately. Reset released mid-count restarts from 0.
- Priority per clock edge: clr > load > count > hold.
- clr: qout<=0, ovf<=0, unf<=0.
- load: qout<=din; flags unchanged; eup/edn ignored that cycle.
- Effective direction: up = eup & ~edn; dn = edn & ~eup. eup=edn=1 or both 0 -> hold; cout=bout=0.
- Stage MAX = 2^STAGE_W-1 (binary), MIN = 0.
- Ripple enable, combinational, same cycle:
  - stage 0 is enabled by up/dn;
  - stage k is enabled up when up and stages 0..k-1 are all MAX;
  - stage k is enabled down when dn and stages 0..k-1 are all 0.
- An enabled stage at MAX (up) wraps to 0; at 0 (down) wraps to MAX.
- cout = up & (all stages MAX); bout = dn & (all stages 0). Both are combinational from current qout and inputs, with zero latency, and are asserted in either mode.
- Wrap mode (sat=0): on cout, qout<=0 and ovf<=1; on bout, qout<=all-MAX and unf<=1.
- Saturate mode (sat=1): on cout, qout holds all-MAX and ovf<=1; on bout, qout holds 0 and unf<=1.
- Count latency: qout reflects an enable one clock after the sampling edge.
- ovf/unf stay set until clr or reset; both may be set at once.
- sat may change any cycle; it affects only the current edge.
- STAGES=1 behaves as a single up/down counter.

Optional Feature:
- Macro: UPDN_CHAIN_BCD_EN.
- Defined:
  - each stage counts decimal, MAX = 9, requiring STAGE_W>=4; upper stage bits stay 0;
  - up from 9 -> 0 and down from 0 -> 9, with the ripple enable using digit==9 / digit==0;
  - on load, any digit >9 is clamped to 9;
  - saturation value is all digits 9.
- Not defined: pure binary behaviour as above, and load is unrestricted.

Test Plan:
- Reset: assert reset mid-count at qout=8'h5A asynchronously -> qout=0, ovf=unf=0 before the next edge; release, eup=1 for 3 clocks -> qout=8'h03.
- Ripple carry (STAGE_W=4, STAGES=2): load 8'h0F, eup=1 one clock -> 8'h10; load 8'h10, edn=1 one clock -> 8'h0F.
- Wrap: sat=0, load 8'hFF, eup=1 -> cout=1 same cycle, next qout=8'h00, ovf=1. Then load 8'h00, edn=1 -> bout=1, qout=8'hFF, unf=1, ovf still 1.
- Saturate: sat=1, load 8'hFE, eup=1 for 3 clocks -> 8'hFF, 8'hFF, 8'hFF; cout=1 on clocks 2-3; ovf=1. clr -> qout=0, ovf=0.
- Priority and conflict: eup=edn=1 at 8'h33 -> hold, cout=bout=0; clr=load=eup=1 -> qout=0; load=1, eup=1, din=8'h42 -> qout=8'h42.
- BCD (macro defined): load 8'h99, eup=1 -> qout=8'h00, ovf=1; load 8'h10, edn=1 -> 8'h09; load 8'hAF -> qout=8'h99.
